axi_eth_rx_frame_fifo: RTL and testbench

Parametrised single-clock store-and-forward receive frame buffer between the Ethernet MAC RX AXI-Stream and the downstream packet path. Each frame is written into a circular buffer and released to the output only once its last beat arrives with a good status. Bad and overflowing frames are rewound out of the buffer, or forwarded with an error flag when so configured. Saturating per-class frame counters are provided. It supersedes the fixed 64-bit receive interface block and adds width/depth parameters, a bad-frame forwarding mode, overflow handling and statistics.

---
 rtl/axi_eth_rx_frame_fifo.sv | 158 +++++++++++++++
 tb/tb_axi_eth_rx_frame_fifo.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_eth_rx_frame_fifo.sv
// Store-and-forward receive frame buffer between the MAC RX AXI-Stream and the packet path.
// Frames are released only once committed; bad or overflowing frames are rewound out of the buffer.
module axi_eth_rx_frame_fifo #(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_DEPTH_LOG2 = 9,
    parameter int C_DROP_BAD   = 1,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                      rx_clk,
    input  logic                      rx_reset,
    input  logic [C_DATA_WIDTH-1:0]   rx_axis_mac_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] rx_axis_mac_tkeep,
    input  logic                      rx_axis_mac_tlast,
    input  logic                      rx_axis_mac_tuser,
    input  logic                      rx_axis_mac_tvalid,
    output logic                      rx_axis_mac_tready,
    output logic [C_DATA_WIDTH-1:0]   mac_tdata,
    output logic [C_DATA_WIDTH/8-1:0] mac_tkeep,
    output logic                      mac_tlast,
    output logic                      mac_tuser,
    output logic                      mac_tvalid,
    input  logic                      mac_tready,
    output logic [C_CNT_WIDTH-1:0]    good_frame_cnt,
    output logic [C_CNT_WIDTH-1:0]    bad_frame_cnt,
    output logic [C_CNT_WIDTH-1:0]    ovf_frame_cnt
);

    localparam int K     = C_DATA_WIDTH / 8;
    localparam int EW    = C_DATA_WIDTH + K + 2;
    localparam int DEPTH = 1 << C_DEPTH_LOG2;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);

    typedef logic [C_DEPTH_LOG2:0] ptr_t;
    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} wr_state_t;

    wr_state_t     state, state_nxt;
    logic [EW-1:0] mem [DEPTH];

    ptr_t wr_ptr, wr_commit, rd_ptr, fe_ptr;
    ptr_t wr_ptr_nxt, wr_commit_nxt;
    ptr_t used;
    logic full;
    logic mem_we;
    logic inc_good, inc_bad, inc_ovf;

    logic          pf_valid;
    logic [EW-1:0] pf_q;
    logic          out_free;
    logic          fetch;

    assign rx_axis_mac_tready = 1'b1;

    // rd_ptr only advances on downstream handshakes, so the output and prefetch stages still occupy space
    assign used = wr_ptr - rd_ptr;
    assign full = (used == ptr_t'(DEPTH));

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        mem_we        = 1'b0;
        inc_good      = 1'b0;
        inc_bad       = 1'b0;
        inc_ovf       = 1'b0;
        if (rx_axis_mac_tvalid) begin
            case (state)
                IDLE, WRITE: begin
                    if (full) begin
                        wr_ptr_nxt = wr_commit;
                        inc_ovf    = 1'b1;
                        state_nxt  = rx_axis_mac_tlast ? IDLE : DISCARD;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + ptr_t'(1);
                        state_nxt  = rx_axis_mac_tlast ? IDLE : WRITE;
                        if (rx_axis_mac_tlast) begin
                            inc_good = rx_axis_mac_tuser;
                            inc_bad  = !rx_axis_mac_tuser;
                            if (rx_axis_mac_tuser || (C_DROP_BAD == 0)) begin
                                wr_commit_nxt = wr_ptr + ptr_t'(1);
                            end else begin
                                wr_ptr_nxt = wr_commit;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (rx_axis_mac_tlast) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (mem_we) begin
            mem[wr_ptr[C_DEPTH_LOG2-1:0]] <= {rx_axis_mac_tdata, rx_axis_mac_tkeep,
                                              rx_axis_mac_tlast, rx_axis_mac_tlast & rx_axis_mac_tuser};
        end
    end

    assign out_free = !mac_tvalid || mac_tready;
    assign fetch    = (fe_ptr != wr_commit) && (!pf_valid || out_free);

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            fe_ptr     <= '0;
            rd_ptr     <= '0;
            pf_valid   <= 1'b0;
            pf_q       <= '0;
            mac_tvalid <= 1'b0;
            mac_tdata  <= '0;
            mac_tkeep  <= '0;
            mac_tlast  <= 1'b0;
            mac_tuser  <= 1'b0;
        end else begin
            if (fetch) begin
                pf_q   <= mem[fe_ptr[C_DEPTH_LOG2-1:0]];
                fe_ptr <= fe_ptr + ptr_t'(1);
            end
            pf_valid <= fetch || (pf_valid && !out_free);
            if (out_free) begin
                mac_tvalid <= pf_valid;
                if (pf_valid) begin
                    {mac_tdata, mac_tkeep, mac_tlast, mac_tuser} <= pf_q;
                end
            end
            if (mac_tvalid && mac_tready) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_reset) begin
            good_frame_cnt <= '0;
            bad_frame_cnt  <= '0;
            ovf_frame_cnt  <= '0;
        end else begin
            if (inc_good && (good_frame_cnt != '1)) good_frame_cnt <= good_frame_cnt + CNT_ONE;
            if (inc_bad && (bad_frame_cnt != '1))   bad_frame_cnt  <= bad_frame_cnt + CNT_ONE;
            if (inc_ovf && (ovf_frame_cnt != '1))   ovf_frame_cnt  <= ovf_frame_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_axi_eth_rx_frame_fifo.sv
// Scoreboard bench: three buffer configurations share one stimulus stream, each checked
// against a frame-level reference model (queues of committed beats, occupancy by count).
`timescale 1ns/1ps
module tb_axi_eth_rx_frame_fifo;
    localparam int N = 3;
    localparam int unsigned DEPTH_C [N] = '{512, 512, 16};
    localparam bit          DROP_C  [N] = '{1'b1, 1'b0, 1'b1};
    localparam int unsigned CMAX_C  [N] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd15};

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    logic        rx_clk   = 1'b0;
    logic        rx_reset = 1'b1;
    logic [63:0] in_data  = '0;
    logic [7:0]  in_keep  = '0;
    logic        in_last  = 1'b0;
    logic        in_user  = 1'b0;
    logic        in_valid = 1'b0;
    logic        mac_tready = 1'b1;

    logic        rdy     [N];
    logic [63:0] o_data  [N];
    logic [7:0]  o_keep  [N];
    logic        o_last  [N];
    logic        o_user  [N];
    logic        o_valid [N];
    logic [31:0] c_good  [N];
    logic [31:0] c_bad   [N];
    logic [31:0] c_ovf   [N];
    logic [3:0]  s_good, s_bad, s_ovf;

    assign c_good[2] = {28'd0, s_good};
    assign c_bad[2]  = {28'd0, s_bad};
    assign c_ovf[2]  = {28'd0, s_ovf};

    always #5 rx_clk = ~rx_clk;

    axi_eth_rx_frame_fifo #(.C_DATA_WIDTH(64), .C_DEPTH_LOG2(9), .C_DROP_BAD(1), .C_CNT_WIDTH(32)) u_drop (
        .rx_clk(rx_clk), .rx_reset(rx_reset),
        .rx_axis_mac_tdata(in_data), .rx_axis_mac_tkeep(in_keep), .rx_axis_mac_tlast(in_last),
        .rx_axis_mac_tuser(in_user), .rx_axis_mac_tvalid(in_valid), .rx_axis_mac_tready(rdy[0]),
        .mac_tdata(o_data[0]), .mac_tkeep(o_keep[0]), .mac_tlast(o_last[0]), .mac_tuser(o_user[0]),
        .mac_tvalid(o_valid[0]), .mac_tready(mac_tready),
        .good_frame_cnt(c_good[0]), .bad_frame_cnt(c_bad[0]), .ovf_frame_cnt(c_ovf[0]));

    axi_eth_rx_frame_fifo #(.C_DATA_WIDTH(64), .C_DEPTH_LOG2(9), .C_DROP_BAD(0), .C_CNT_WIDTH(32)) u_fwd (
        .rx_clk(rx_clk), .rx_reset(rx_reset),
        .rx_axis_mac_tdata(in_data), .rx_axis_mac_tkeep(in_keep), .rx_axis_mac_tlast(in_last),
        .rx_axis_mac_tuser(in_user), .rx_axis_mac_tvalid(in_valid), .rx_axis_mac_tready(rdy[1]),
        .mac_tdata(o_data[1]), .mac_tkeep(o_keep[1]), .mac_tlast(o_last[1]), .mac_tuser(o_user[1]),
        .mac_tvalid(o_valid[1]), .mac_tready(mac_tready),
        .good_frame_cnt(c_good[1]), .bad_frame_cnt(c_bad[1]), .ovf_frame_cnt(c_ovf[1]));

    axi_eth_rx_frame_fifo #(.C_DATA_WIDTH(64), .C_DEPTH_LOG2(4), .C_DROP_BAD(1), .C_CNT_WIDTH(4)) u_small (
        .rx_clk(rx_clk), .rx_reset(rx_reset),
        .rx_axis_mac_tdata(in_data), .rx_axis_mac_tkeep(in_keep), .rx_axis_mac_tlast(in_last),
        .rx_axis_mac_tuser(in_user), .rx_axis_mac_tvalid(in_valid), .rx_axis_mac_tready(rdy[2]),
        .mac_tdata(o_data[2]), .mac_tkeep(o_keep[2]), .mac_tlast(o_last[2]), .mac_tuser(o_user[2]),
        .mac_tvalid(o_valid[2]), .mac_tready(mac_tready),
        .good_frame_cnt(s_good), .bad_frame_cnt(s_bad), .ovf_frame_cnt(s_ovf));

    beat_t       exp_q [N][$];
    beat_t       cur   [N][$];
    int unsigned outstanding [N];
    bit          discard [N];
    int unsigned m_good [N];
    int unsigned m_bad  [N];
    int unsigned m_ovf  [N];
    int unsigned popped [N];
    beat_t       prev_b [N];
    bit          prev_stall [N];
    int          checks = 0;
    int          errors = 0;
    bit          armed  = 1'b0;
    bit          rnd_done;

    task automatic chk(input string name, input int inst, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
        end
    endtask

    // Reference model: a frame is collected in cur[] and appended to the expected stream when it
    // ends well; space is committed-but-unconsumed beats plus the frame being collected.
    task automatic model_beat(input int i);
        beat_t b;
        if (discard[i]) begin
            if (in_last) discard[i] = 1'b0;
            return;
        end
        if (outstanding[i] + cur[i].size() == DEPTH_C[i]) begin
            if (m_ovf[i] != CMAX_C[i]) m_ovf[i]++;
            cur[i].delete();
            discard[i] = !in_last;
            return;
        end
        b.data = in_data;
        b.keep = in_keep;
        b.last = in_last;
        b.user = in_last & in_user;
        cur[i].push_back(b);
        if (in_last) begin
            if (in_user) begin
                if (m_good[i] != CMAX_C[i]) m_good[i]++;
            end else begin
                if (m_bad[i] != CMAX_C[i]) m_bad[i]++;
            end
            if (in_user || !DROP_C[i]) begin
                foreach (cur[i][j]) exp_q[i].push_back(cur[i][j]);
                outstanding[i] += cur[i].size();
            end
            cur[i].delete();
        end
    endtask

    always @(negedge rx_clk) begin
        for (int i = 0; i < N; i++) begin
            if (rx_reset) begin
                exp_q[i].delete();
                cur[i].delete();
                outstanding[i] = 0;
                discard[i]     = 1'b0;
                m_good[i]      = 0;
                m_bad[i]       = 0;
                m_ovf[i]       = 0;
            end else begin
                if (armed) begin
                    chk("good_frame_cnt", i, 128'(c_good[i]), 128'(m_good[i]));
                    chk("bad_frame_cnt", i, 128'(c_bad[i]), 128'(m_bad[i]));
                    chk("ovf_frame_cnt", i, 128'(c_ovf[i]), 128'(m_ovf[i]));
                    chk("tready", i, 128'(rdy[i]), 128'(1));
                end
                if (in_valid) model_beat(i);
                if (o_valid[i] && mac_tready && outstanding[i] > 0) outstanding[i]--;
            end
        end
    end

    always @(negedge rx_clk) begin
        for (int i = 0; i < N; i++) begin
            beat_t cb;
            beat_t e;
            cb.data = o_data[i];
            cb.keep = o_keep[i];
            cb.last = o_last[i];
            cb.user = o_user[i];
            if (prev_stall[i]) begin
                chk("hold_valid", i, 128'(o_valid[i]), 128'(1));
                chk("hold_beat", i, 128'(cb), 128'(prev_b[i]));
            end
            if (armed && !rx_reset && o_valid[i] && mac_tready) begin
                chk("beat_expected", i, 128'(exp_q[i].size() > 0), 128'(1));
                if (exp_q[i].size() > 0) begin
                    e = exp_q[i].pop_front();
                    chk("out_beat", i, 128'(cb), 128'(e));
                end
                popped[i]++;
            end
            prev_stall[i] = armed && !rx_reset && o_valid[i] && !mac_tready;
            prev_b[i]     = cb;
        end
    end

    task automatic cyc();
        @(posedge rx_clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        in_last  = l;
        in_user  = u;
        cyc();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic frame(input int len, input bit good, input bit seq);
        for (int b = 1; b <= len; b++) begin
            if (seq) drive(64'(b), 8'(b), b == len, good && (b == len));
            else drive({$urandom, $urandom}, 8'($urandom), b == len,
                       (b == len) ? good : 1'($urandom));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (exp_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int n = 0;
        mac_tready = 1'b1;
        while (pending() && n < 3000) begin
            cyc();
            n++;
        end
        chk("drain_done", 0, 128'(pending()), 128'(0));
        idle(4);
    endtask

    task automatic do_reset();
        rx_reset = 1'b1;
        in_valid = 1'b0;
        cyc();
        cyc();
        rx_reset = 1'b0;
        for (int i = 0; i < N; i++) popped[i] = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        armed = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk("rst_tvalid", i, 128'(o_valid[i]), 128'(0));
            chk("rst_tdata", i, 128'(o_data[i]), 128'(0));
            chk("rst_tkeep", i, 128'(o_keep[i]), 128'(0));
            chk("rst_tlast_tuser", i, 128'({o_last[i], o_user[i]}), 128'(0));
        end

        // single good frame with latency check
        frame(10, 1'b1, 1'b1);
        chk("lat_edge_n", 0, 128'(o_valid[0]), 128'(0));
        cyc();
        chk("lat_edge_n1", 0, 128'(o_valid[0]), 128'(0));
        cyc();
        chk("lat_edge_n2", 0, 128'(o_valid[0]), 128'(1));
        chk("lat_first_data", 0, 128'(o_data[0]), 128'(1));
        drain();
        chk("good1_cnt", 0, 128'(c_good[0]), 128'(1));
        chk("good1_beats", 0, 128'(popped[0]), 128'(10));

        // mixed good/bad frames back to back
        do_reset();
        frame(10, 1'b1, 1'b1);
        frame(23, 1'b0, 1'b1);
        frame(11, 1'b1, 1'b1);
        frame(30, 1'b0, 1'b1);
        frame(40, 1'b0, 1'b1);
        drain();
        chk("dropbad_good", 0, 128'(c_good[0]), 128'(2));
        chk("dropbad_bad", 0, 128'(c_bad[0]), 128'(3));
        chk("dropbad_beats", 0, 128'(popped[0]), 128'(21));
        chk("fwdbad_beats", 1, 128'(popped[1]), 128'(114));

        // bad frame forwarded
        do_reset();
        frame(23, 1'b0, 1'b1);
        drain();
        chk("fwd_bad_cnt", 1, 128'(c_bad[1]), 128'(1));
        chk("fwd_beats", 1, 128'(popped[1]), 128'(23));
        chk("drop_beats", 0, 128'(popped[0]), 128'(0));

        // overflow on the 16-entry instance
        do_reset();
        mac_tready = 1'b0;
        frame(12, 1'b1, 1'b1);
        frame(13, 1'b1, 1'b1);
        idle(5);
        chk("ovf_cnt", 2, 128'(c_ovf[2]), 128'(1));
        chk("ovf_held", 2, 128'(popped[2]), 128'(0));
        drain();
        chk("ovf_first_beats", 2, 128'(popped[2]), 128'(12));
        frame(3, 1'b1, 1'b1);
        drain();
        chk("ovf_after_beats", 2, 128'(popped[2]), 128'(15));
        chk("ovf_good_cnt", 2, 128'(c_good[2]), 128'(2));

        // alternating backpressure
        do_reset();
        fork
            frame(15, 1'b1, 1'b1);
            begin
                repeat (60) begin
                    mac_tready = ~mac_tready;
                    cyc();
                end
            end
        join
        drain();
        chk("bp_beats", 0, 128'(popped[0]), 128'(15));

        // reset during beat 6 of a 14-beat frame
        for (int b = 1; b <= 14; b++) begin
            rx_reset = (b == 6);
            drive(64'(b), 8'(b), b == 14, b == 14);
            if (b == 6) begin
                for (int i = 0; i < N; i++) begin
                    chk("midrst_tvalid", i, 128'(o_valid[i]), 128'(0));
                    chk("midrst_tdata", i, 128'(o_data[i]), 128'(0));
                    chk("midrst_cnts", i, 128'({c_good[i], c_bad[i], c_ovf[i]}), 128'(0));
                    popped[i] = 0;
                end
            end
        end
        rx_reset = 1'b0;
        in_valid = 1'b0;
        frame(16, 1'b1, 1'b1);
        drain();
        chk("midrst_good", 0, 128'(c_good[0]), 128'(2));
        chk("midrst_beats", 0, 128'(popped[0]), 128'(24));

        // randomized frames, gaps and backpressure
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                repeat (100) begin
                    frame($urandom_range(1, 40), $urandom_range(0, 3) != 0, 1'b0);
                    idle($urandom_range(0, 3));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    mac_tready = ($urandom_range(0, 3) != 0);
                    cyc();
                end
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
